dmem_lsu: RTL and testbench

Load/store unit that initiates word and byte accesses to the single-port data memory on behalf of the execute stage. It accepts one request at a time over a valid/ready handshake, forms the effective address and checks alignment and range. It drives the memory's opcode/address/write-data port and returns loaded data to the register-file write-back port. Byte stores are done as read-modify-write over the word-wide memory port.

---
 rtl/dmem_lsu_if.sv | 35 +++
 rtl/dmem_lsu.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request, data-memory and write-back signals of the load/store unit.
// slave  = the LSU itself; master = the environment (execute stage, memory, register file).
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_base;
  logic [15:0] req_imm;
  logic [4:0]  req_rt;
  logic [31:0] req_wdata;

  logic [5:0]  mem_opcode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        wb_valid;
  logic [4:0]  wb_rt;
  logic [31:0] wb_data;

  logic        err;
  logic [1:0]  err_code;

  modport slave (
    input  req_valid, req_opcode, req_base, req_imm, req_rt, req_wdata, mem_rdata,
    output req_ready, mem_opcode, mem_addr, mem_wdata, wb_valid, wb_rt, wb_data,
           err, err_code
  );

  modport master (
    output req_valid, req_opcode, req_base, req_imm, req_rt, req_wdata, mem_rdata,
    input  req_ready, mem_opcode, mem_addr, mem_wdata, wb_valid, wb_rt, wb_data,
           err, err_code
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: one-request-at-a-time load/store unit for the word-wide data memory.
// Word accesses (LW/SW) always; byte accesses (LB/LBU and SB as read-modify-write)
// only when the macro DMEM_LSU_BYTE_EN is defined, otherwise they report err_code 01.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready for a request; request fields latched on handshake
// S_ADDR   | effective address formed, opcode/alignment/range checked
// S_MEM_RD | memory word read, captured at end of cycle
// S_MEM_WR | memory write strobe (word, or merged word for SB)
// S_WB     | register write-back strobe (suppressed for rt = 0)
// S_ERR    | one-cycle error strobe with code
module dmem_lsu #(
  parameter int DEPTH = 256
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_MEM_RD, S_MEM_WR, S_WB, S_ERR
  } state_t;

  localparam logic [5:0]  OP_LW   = 6'b100011;
  localparam logic [5:0]  OP_SW   = 6'b101011;
  localparam logic [5:0]  OP_NONE = 6'b000000;
`ifdef DMEM_LSU_BYTE_EN
  localparam logic [5:0]  OP_LB   = 6'b100000;
  localparam logic [5:0]  OP_LBU  = 6'b100100;
  localparam logic [5:0]  OP_SB   = 6'b101000;
`endif
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] base_q, base_d;
  logic [15:0] imm_q, imm_d;
  logic [4:0]  rt_q, rt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [29:0] widx_q, widx_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  errc_q, errc_d;

  logic [31:0] ea;
  logic        is_word;
  logic        op_ok;

`ifdef DMEM_LSU_BYTE_EN
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  lane_byte;
  logic [31:0] merged;
`endif

  // Effective address (32-bit wrap) and opcode classification.
  always_comb begin
    ea      = base_q + {{16{imm_q[15]}}, imm_q};
    is_word = (op_q == OP_LW) || (op_q == OP_SW);
`ifdef DMEM_LSU_BYTE_EN
    op_ok   = is_word || (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_SB);
`else
    op_ok   = is_word;
`endif
  end

`ifdef DMEM_LSU_BYTE_EN
  // Byte lane extraction for loads and lane merge for the SB write-back word.
  always_comb begin
    lane_byte = rdata_q[7:0];
    merged    = rdata_q;
    case (lane_q)
      2'd0: begin lane_byte = rdata_q[7:0];   merged[7:0]   = wdata_q[7:0]; end
      2'd1: begin lane_byte = rdata_q[15:8];  merged[15:8]  = wdata_q[7:0]; end
      2'd2: begin lane_byte = rdata_q[23:16]; merged[23:16] = wdata_q[7:0]; end
      default: begin lane_byte = rdata_q[31:24]; merged[31:24] = wdata_q[7:0]; end
    endcase
  end
`endif

  // Next-state logic and request/operand capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    imm_d   = imm_q;
    rt_d    = rt_q;
    wdata_d = wdata_q;
    widx_d  = widx_q;
    rdata_d = rdata_q;
    errc_d  = errc_q;
`ifdef DMEM_LSU_BYTE_EN
    lane_d  = lane_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_opcode;
          base_d  = bus.req_base;
          imm_d   = bus.req_imm;
          rt_d    = bus.req_rt;
          wdata_d = bus.req_wdata;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        widx_d = ea[31:2];
`ifdef DMEM_LSU_BYTE_EN
        lane_d = ea[1:0];
`endif
        if (!op_ok) begin
          errc_d  = 2'b01;
          state_d = S_ERR;
        end else if (is_word && (ea[1:0] != 2'b00)) begin
          errc_d  = 2'b10;
          state_d = S_ERR;
        end else if ({2'b00, ea[31:2]} >= DEPTH_W) begin
          errc_d  = 2'b11;
          state_d = S_ERR;
        end else if (op_q == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        rdata_d = bus.mem_rdata;
`ifdef DMEM_LSU_BYTE_EN
        state_d = (op_q == OP_SB) ? S_MEM_WR : S_WB;
`else
        state_d = S_WB;
`endif
      end
      S_MEM_WR: state_d = S_IDLE;
      S_WB:     state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so they stay settled all cycle
  // and drop to idle values as soon as reset clears the state.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.mem_opcode = OP_NONE;
    bus.mem_addr   = 32'h0;
    bus.mem_wdata  = 32'h0;
    bus.wb_valid   = 1'b0;
    bus.wb_rt      = 5'd0;
    bus.wb_data    = 32'h0;
    bus.err        = 1'b0;
    bus.err_code   = 2'b00;
    case (state_q)
      S_IDLE:   bus.req_ready = 1'b1;
      S_MEM_RD: bus.mem_addr  = {2'b00, widx_q};
      S_MEM_WR: begin
        bus.mem_opcode = OP_SW;
        bus.mem_addr   = {2'b00, widx_q};
        bus.mem_wdata  = wdata_q;
`ifdef DMEM_LSU_BYTE_EN
        if (op_q == OP_SB) bus.mem_wdata = merged;
`endif
      end
      S_WB: begin
        bus.wb_valid = (rt_q != 5'd0);
        bus.wb_rt    = rt_q;
        bus.wb_data  = rdata_q;
`ifdef DMEM_LSU_BYTE_EN
        if (op_q == OP_LB)  bus.wb_data = {{24{lane_byte[7]}}, lane_byte};
        if (op_q == OP_LBU) bus.wb_data = {24'h0, lane_byte};
`endif
      end
      S_ERR: begin
        bus.err      = 1'b1;
        bus.err_code = errc_q;
      end
      default: ;
    endcase
  end

  // State and operand registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 6'h0;
      base_q  <= 32'h0;
      imm_q   <= 16'h0;
      rt_q    <= 5'd0;
      wdata_q <= 32'h0;
      widx_q  <= 30'h0;
      rdata_q <= 32'h0;
      errc_q  <= 2'b00;
`ifdef DMEM_LSU_BYTE_EN
      lane_q  <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      imm_q   <= imm_d;
      rt_q    <= rt_d;
      wdata_q <= wdata_d;
      widx_q  <= widx_d;
      rdata_q <= rdata_d;
      errc_q  <= errc_d;
`ifdef DMEM_LSU_BYTE_EN
      lane_q  <= lane_d;
`endif
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed table, hand sequences and random requests for dmem_lsu,
// with a word-array memory and a transaction-level reference model.
module tb_dmem_lsu;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] BAD = 6'b001000;
`ifdef DMEM_LSU_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  ready_cyc;
    logic [7:0]  wb_cnt;
    logic [7:0]  wb_cyc;
    logic [4:0]  wb_rt;
    logic [31:0] wb_data;
    logic [7:0]  err_cnt;
    logic [7:0]  err_cyc;
    logic [1:0]  err_code;
    logic [7:0]  wr_cnt;
    logic [7:0]  wr_cyc;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  bad_op;
  } obs_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] base;
    logic [15:0] imm;
    logic [4:0]  rt;
    logic [31:0] wdata;
    obs_t        exp;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  dmem_lsu_if bus();

  dmem_lsu #(.DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  bit mem_init = 1'b0;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
      mem_init <= 1'b1;
    end else if (bus.mem_opcode == SW && bus.mem_addr < 32'd256) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = (bus.mem_addr < 32'd256) ? mem[bus.mem_addr[7:0]] : 32'h0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(int ready, bit wb, logic [4:0] rt, logic [31:0] wbd,
                              logic [1:0] ec, bit wr, logic [31:0] wa, logic [31:0] wd, int wcyc);
    obs_t e;
    e = '0;
    e.ready_cyc = 8'(ready);
    if (wb) begin
      e.wb_cnt = 8'd1; e.wb_cyc = 8'd3; e.wb_rt = rt; e.wb_data = wbd;
    end
    if (ec != 2'b00) begin
      e.err_cnt = 8'd1; e.err_cyc = 8'd2; e.err_code = ec;
    end
    if (wr) begin
      e.wr_cnt = 8'd1; e.wr_cyc = 8'(wcyc); e.wr_addr = wa; e.wr_data = wd;
    end
    return e;
  endfunction

  // Reference: outcome of one request from the architectural rules and ref_mem.
  function automatic obs_t model(logic [5:0] op, logic [31:0] base, logic [15:0] imm,
                                 logic [4:0] rt, logic [31:0] wdata);
    logic [31:0] ea, idx, word, byt;
    int sh;
    bit byte_op, known;
    logic [1:0] code;
    ea      = base + {{16{imm[15]}}, imm};
    idx     = ea / 4;
    sh      = int'(ea % 4) * 8;
    byte_op = (op == LB) || (op == LBU) || (op == SB);
    known   = (op == LW) || (op == SW) || (BYTE_EN && byte_op);
    code    = 2'b00;
    if (!known) code = 2'b01;
    else if (!byte_op && (ea % 4) != 0) code = 2'b10;
    else if (idx >= 256) code = 2'b11;
    if (code != 2'b00) return mk(3, 0, 0, 0, code, 0, 0, 0, 0);
    word = ref_mem[idx[7:0]];
    byt  = (word >> sh) & 32'hFF;
    if (op == SW)  return mk(3, 0, 0, 0, 0, 1, idx, wdata, 2);
    if (op == SB)  return mk(4, 0, 0, 0, 0, 1, idx,
                             (word & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh), 3);
    if (op == LW)  return mk(4, rt != 0, rt, word, 0, 0, 0, 0, 0);
    if (op == LB)  return mk(4, rt != 0, rt, (byt >= 128) ? byt - 32'd256 : byt, 0, 0, 0, 0, 0);
    return mk(4, rt != 0, rt, byt, 0, 0, 0, 0, 0);
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%0d wb=%0d@%0d rt=%0d d=%h err=%0d@%0d c=%0d wr=%0d@%0d a=%0h d=%h badop=%0d | required rdy=%0d wb=%0d@%0d rt=%0d d=%h err=%0d@%0d c=%0d wr=%0d@%0d a=%0h d=%h badop=%0d",
               name, got.ready_cyc, got.wb_cnt, got.wb_cyc, got.wb_rt, got.wb_data, got.err_cnt,
               got.err_cyc, got.err_code, got.wr_cnt, got.wr_cyc, got.wr_addr, got.wr_data, got.bad_op,
               exp.ready_cyc, exp.wb_cnt, exp.wb_cyc, exp.wb_rt, exp.wb_data, exp.err_cnt,
               exp.err_cyc, exp.err_code, exp.wr_cnt, exp.wr_cyc, exp.wr_addr, exp.wr_data, exp.bad_op);
    end
  endtask

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // One request: handshake, then watch the unit cycle by cycle until ready again.
  // Request inputs are scrambled while busy to show they are only sampled at the handshake.
  task automatic run_req(input logic [5:0] op, input logic [31:0] base, input logic [15:0] imm,
                         input logic [4:0] rt, input logic [31:0] wdata, output obs_t o);
    int n;
    o = '0;
    n = 0;
    while (!bus.req_ready && n < 10) begin @(negedge clk); n++; end
    bus.req_opcode = op;
    bus.req_base   = base;
    bus.req_imm    = imm;
    bus.req_rt     = rt;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.req_ready) begin o.ready_cyc = 8'(c); break; end
      if (bus.wb_valid) begin
        o.wb_cnt++; o.wb_cyc = 8'(c); o.wb_rt = bus.wb_rt; o.wb_data = bus.wb_data;
      end
      if (bus.err) begin
        o.err_cnt++; o.err_cyc = 8'(c); o.err_code = bus.err_code;
      end
      if (bus.mem_opcode == SW) begin
        o.wr_cnt++; o.wr_cyc = 8'(c); o.wr_addr = bus.mem_addr; o.wr_data = bus.mem_wdata;
      end else if (bus.mem_opcode != 6'b000000) begin
        o.bad_op++;
      end
      bus.req_valid  = 1'($urandom);
      bus.req_opcode = 6'($urandom);
      bus.req_base   = $urandom;
      bus.req_imm    = 16'($urandom);
      bus.req_rt     = 5'($urandom);
      bus.req_wdata  = $urandom;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic add(input string name, input logic [5:0] op, input logic [31:0] base,
                     input logic [15:0] imm, input logic [4:0] rt, input logic [31:0] wdata,
                     input obs_t exp, inout vec_t tbl[$]);
    vec_t v;
    v.name = name; v.op = op; v.base = base; v.imm = imm; v.rt = rt; v.wdata = wdata; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t  tbl[$];
    obs_t  got, exp;
    int    acc[3];
    int    k, n, bad_words;
    logic [5:0]  op;
    logic [31:0] base;
    logic [15:0] imm;
    logic [31:0] pre9;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 + 32'(i);
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_opcode = 6'h0; bus.req_base = 32'h0;
    bus.req_imm = 16'h0; bus.req_rt = 5'd0; bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs",
              {bus.req_ready, bus.mem_opcode, bus.mem_addr, bus.mem_wdata, bus.wb_valid,
               bus.wb_rt, bus.wb_data, bus.err, bus.err_code},
              {1'b1, 6'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 2'b00});
    rst = 1'b0;
    @(negedge clk);

    add("sw_word5",   SW, 32'h10, 16'h0004, 5'd7, 32'hDEADBEEF, mk(3,0,0,0,0,1,5,32'hDEADBEEF,2), tbl);
    add("lw_word5",   LW, 32'h10, 16'h0004, 5'd3, 32'h0, mk(4,1,3,32'hDEADBEEF,0,0,0,0,0), tbl);
`ifdef DMEM_LSU_BYTE_EN
    add("sb_lane2",   SB,  32'h10, 16'h0006, 5'd1, 32'h80, mk(4,0,0,0,0,1,5,32'hDE80BEEF,3), tbl);
    add("lb_lane2",   LB,  32'h16, 16'h0000, 5'd4, 32'h0, mk(4,1,4,32'hFFFFFF80,0,0,0,0,0), tbl);
    add("lbu_lane2",  LBU, 32'h16, 16'h0000, 5'd5, 32'h0, mk(4,1,5,32'h00000080,0,0,0,0,0), tbl);
    add("lbu_lane3",  LBU, 32'h17, 16'h0000, 5'd6, 32'h0, mk(4,1,6,32'h000000DE,0,0,0,0,0), tbl);
`else
    add("sb_unsup",   SB,  32'h10, 16'h0006, 5'd1, 32'h80, mk(3,0,0,0,1,0,0,0,0), tbl);
    add("lb_unsup",   LB,  32'h16, 16'h0000, 5'd4, 32'h0, mk(3,0,0,0,1,0,0,0,0), tbl);
    add("lbu_unsup",  LBU, 32'h16, 16'h0000, 5'd5, 32'h0, mk(3,0,0,0,1,0,0,0,0), tbl);
    add("lbu3_unsup", LBU, 32'h17, 16'h0000, 5'd6, 32'h0, mk(3,0,0,0,1,0,0,0,0), tbl);
`endif
    add("lw_misalign",    LW,  32'h20, 16'hFFFE, 5'd8, 32'h0, mk(3,0,0,0,2,0,0,0,0), tbl);
    add("bad_opcode",     BAD, 32'h10, 16'h0000, 5'd8, 32'h0, mk(3,0,0,0,1,0,0,0,0), tbl);
    add("lw_range",       LW,  32'h400, 16'h0000, 5'd8, 32'h0, mk(3,0,0,0,3,0,0,0,0), tbl);
    add("unsup_over_mis", BAD, 32'h11, 16'h0000, 5'd8, 32'h0, mk(3,0,0,0,1,0,0,0,0), tbl);
    add("mis_over_range", LW,  32'h1001, 16'h0000, 5'd8, 32'h0, mk(3,0,0,0,2,0,0,0,0), tbl);
    add("sw_misalign",    SW,  32'h12, 16'h0000, 5'd8, 32'h1, mk(3,0,0,0,2,0,0,0,0), tbl);
    add("lw_rt0",         LW,  32'h14, 16'h0000, 5'd0, 32'h0, mk(4,0,0,0,0,0,0,0,0), tbl);
    add("sw_top",         SW,  32'h3FC, 16'h0000, 5'd0, 32'h12345678, mk(3,0,0,0,0,1,255,32'h12345678,2), tbl);
    add("lw_top_negimm",  LW,  32'h400, 16'hFFFC, 5'd31, 32'h0, mk(4,1,31,32'h12345678,0,0,0,0,0), tbl);
    add("sw_wrap",        SW,  32'hFFFFFFFC, 16'h0008, 5'd2, 32'hCAFEF00D, mk(3,0,0,0,0,1,1,32'hCAFEF00D,2), tbl);
    add("lw_wrap",        LW,  32'h0, 16'h0004, 5'd9, 32'h0, mk(4,1,9,32'hCAFEF00D,0,0,0,0,0), tbl);
    add("lw_neg_range",   LW,  32'h0, 16'hFFFC, 5'd9, 32'h0, mk(3,0,0,0,3,0,0,0,0), tbl);

    foreach (tbl[i]) begin
      run_req(tbl[i].op, tbl[i].base, tbl[i].imm, tbl[i].rt, tbl[i].wdata, got);
      check_obs(tbl[i].name, got, tbl[i].exp);
      if (tbl[i].exp.wr_cnt != 0) ref_mem[tbl[i].exp.wr_addr[7:0]] = tbl[i].exp.wr_data;
    end

    // req_valid held high across LW, SW, LW: accepts only when idle.
    acc[0] = -100; acc[1] = -100; acc[2] = -100;
    k = 0;
    bus.req_opcode = LW; bus.req_base = 32'h14; bus.req_imm = 16'h0;
    bus.req_rt = 5'd2; bus.req_wdata = 32'h0; bus.req_valid = 1'b1;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc[k] = cyc;
        k++;
        @(posedge clk);
        #1;
        if (k == 1) begin
          bus.req_opcode = SW; bus.req_base = 32'h18; bus.req_wdata = 32'h0BADCAFE;
        end else if (k == 2) begin
          bus.req_opcode = LW; bus.req_base = 32'h18; bus.req_rt = 5'd2;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    ref_mem[6] = 32'h0BADCAFE;
    check_val("b2b_spacing_lw", 128'(acc[1] - acc[0]), 128'd4);
    check_val("b2b_spacing_sw", 128'(acc[2] - acc[1]), 128'd3);
    n = 0;
    while (!bus.req_ready && n < 10) begin @(negedge clk); n++; end

    // Random requests against the reference model.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0, 1: op = LW;
        2, 3: op = SW;
        4:    op = LB;
        5:    op = LBU;
        6:    op = SB;
        default: op = ($urandom_range(0, 1) == 0) ? BAD : 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       base = $urandom;
        1:       base = 32'h3F0 + 32'($urandom_range(0, 31));
        default: base = 32'($urandom_range(0, 32'h3FF));
      endcase
      if ($urandom_range(0, 1) == 0) base = base & 32'hFFFFFFFC;
      imm = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 5) == 0) imm = 16'hFFFC;
      begin
        logic [4:0]  rt;
        logic [31:0] wd;
        rt = 5'($urandom);
        wd = $urandom;
        exp = model(op, base, imm, rt, wd);
        run_req(op, base, imm, rt, wd, got);
        check_obs("random_req", got, exp);
        if (exp.wr_cnt != 0) ref_mem[exp.wr_addr[7:0]] = exp.wr_data;
      end
    end

    // Reset during the write cycle of a SW: write must be cancelled.
    pre9 = ref_mem[9];
    n = 0;
    while (!bus.req_ready && n < 10) begin @(negedge clk); n++; end
    bus.req_opcode = SW; bus.req_base = 32'h24; bus.req_imm = 16'h0;
    bus.req_rt = 5'd1; bus.req_wdata = ~pre9; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_in_write", 128'(bus.mem_opcode), 128'(SW));
    rst = 1'b1;
    #1;
    check_val("midrst_opcode_cleared", 128'(bus.mem_opcode), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_word_kept", 128'(mem[9]), 128'(pre9));
    check_val("midrst_ready_idle", {bus.req_ready, bus.wb_valid, bus.err}, {1'b1, 1'b0, 1'b0});

    bad_words = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad_words++;
    check_val("final_memory_words_wrong", 128'(bad_words), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
